// File: rtl/pkt_pack16to32.sv
// Packs a framed 16-bit beat stream into 32-bit words with byte-accurate mty and a channel tag.
// Malformed beats are flagged on err; packet and error counters run alongside.
module pkt_pack16to32 #(
    parameter int              CNT_W   = 16,
    parameter logic [CNT_W-1:0] ERR_MAX = {CNT_W{1'b1}}
) (
    input  logic             clk_d,
    input  logic             rst,
    input  logic [15:0]      din,
    input  logic             din_vld,
    input  logic             din_sop,
    input  logic             din_eop,
    input  logic             din_mty,
    input  logic [1:0]       din_chan,
    output logic [31:0]      dout,
    output logic             dout_vld,
    output logic             dout_sop,
    output logic             dout_eop,
    output logic [1:0]       dout_mty,
    output logic [1:0]       dout_chan,
    output logic             err,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] err_cnt
);
    typedef enum logic [1:0] {IDLE, HAVE_HI, IN_PKT} state_t;

    state_t      state_q, state_d;
    logic [15:0] hold_q, hold_d;
    logic        sop_pend_q, sop_pend_d;
    logic [1:0]  chan_q, chan_d;

    logic        vld_d, sop_d, eop_d, err_d, pkt_inc, mty_eff;
    logic [31:0] word_d;
    logic [1:0]  mty_d, ochan_d;

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        sop_pend_d = sop_pend_q;
        chan_d     = chan_q;
        vld_d      = 1'b0;
        sop_d      = 1'b0;
        eop_d      = 1'b0;
        err_d      = 1'b0;
        pkt_inc    = 1'b0;
        word_d     = '0;
        mty_d      = '0;
        ochan_d    = '0;
        // mty only means something on an eop beat; elsewhere it is an error and ignored
        mty_eff    = din_mty & din_eop;
        if (din_vld) begin
            if (din_mty && !din_eop)
                err_d = 1'b1;
            if (din_sop) begin
                // a sop anywhere restarts framing; anything held is abandoned
                if (state_q != IDLE)
                    err_d = 1'b1;
                chan_d = din_chan;
                if (din_eop) begin
                    vld_d      = 1'b1;
                    sop_d      = 1'b1;
                    eop_d      = 1'b1;
                    word_d     = {din, 16'h0};
                    mty_d      = {1'b1, mty_eff};
                    ochan_d    = din_chan;
                    pkt_inc    = 1'b1;
                    sop_pend_d = 1'b0;
                    state_d    = IDLE;
                end else begin
                    hold_d     = din;
                    sop_pend_d = 1'b1;
                    state_d    = HAVE_HI;
                end
            end else if (state_q == IDLE) begin
                err_d = 1'b1;
            end else begin
                if (din_chan != chan_q)
                    err_d = 1'b1;
                if (state_q == HAVE_HI) begin
                    vld_d      = 1'b1;
                    sop_d      = sop_pend_q;
                    sop_pend_d = 1'b0;
                    word_d     = {hold_q, din};
                    ochan_d    = chan_q;
                    if (din_eop) begin
                        eop_d   = 1'b1;
                        mty_d   = {1'b0, mty_eff};
                        pkt_inc = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = IN_PKT;
                    end
                end else if (din_eop) begin
                    vld_d   = 1'b1;
                    eop_d   = 1'b1;
                    word_d  = {din, 16'h0};
                    mty_d   = {1'b1, mty_eff};
                    ochan_d = chan_q;
                    pkt_inc = 1'b1;
                    state_d = IDLE;
                end else begin
                    hold_d  = din;
                    state_d = HAVE_HI;
                end
            end
        end
    end

    always_ff @(posedge clk_d or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            sop_pend_q <= 1'b0;
            chan_q     <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            sop_pend_q <= sop_pend_d;
            chan_q     <= chan_d;
        end
    end

    always_ff @(posedge clk_d or posedge rst) begin
        if (rst) begin
            dout      <= '0;
            dout_vld  <= 1'b0;
            dout_sop  <= 1'b0;
            dout_eop  <= 1'b0;
            dout_mty  <= '0;
            dout_chan <= '0;
            err       <= 1'b0;
            pkt_cnt   <= '0;
            err_cnt   <= '0;
        end else begin
            dout      <= word_d;
            dout_vld  <= vld_d;
            dout_sop  <= sop_d;
            dout_eop  <= eop_d;
            dout_mty  <= mty_d;
            dout_chan <= ochan_d;
            err       <= err_d;
            pkt_cnt   <= pkt_cnt + CNT_W'(pkt_inc);
            if (err_d && err_cnt != ERR_MAX)
                err_cnt <= err_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pkt_pack16to32.sv
// Bench for pkt_pack16to32: directed scenarios then random framing, checked against a
// queue-based packet model. Narrow counters make wrap and saturation reachable.
module tb_pkt_pack16to32;
    localparam int CNT_W = 4;
    localparam int ERR_MAX = (1 << CNT_W) - 1;

    logic             clk_d = 1'b0;
    logic             rst;
    logic [15:0]      din;
    logic             din_vld, din_sop, din_eop, din_mty;
    logic [1:0]       din_chan;
    logic [31:0]      dout;
    logic             dout_vld, dout_sop, dout_eop;
    logic [1:0]       dout_mty, dout_chan;
    logic             err;
    logic [CNT_W-1:0] pkt_cnt, err_cnt;

    pkt_pack16to32 #(.CNT_W(CNT_W)) dut (
        .clk_d(clk_d), .rst(rst), .din(din), .din_vld(din_vld), .din_sop(din_sop),
        .din_eop(din_eop), .din_mty(din_mty), .din_chan(din_chan), .dout(dout),
        .dout_vld(dout_vld), .dout_sop(dout_sop), .dout_eop(dout_eop), .dout_mty(dout_mty),
        .dout_chan(dout_chan), .err(err), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
    );

    always #5 clk_d = ~clk_d;

    int vectors = 0;
    int miscompares = 0;

    // reference model: half-words of the open packet waiting to be paired
    logic [15:0] hq[$];
    bit          m_in, m_first;
    logic [1:0]  m_chan;
    int          m_pkt, m_err;
    bit          e_vld, e_sop, e_eop, e_err;
    logic [31:0] e_dout;
    logic [1:0]  e_mty, e_chan;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, "_vld"}, 32'(dout_vld), 32'(e_vld));
        if (e_vld) begin
            chk({tag, "_dout"}, dout, e_dout);
            chk({tag, "_sop"}, 32'(dout_sop), 32'(e_sop));
            chk({tag, "_eop"}, 32'(dout_eop), 32'(e_eop));
            chk({tag, "_mty"}, 32'(dout_mty), 32'(e_mty));
            chk({tag, "_chan"}, 32'(dout_chan), 32'(e_chan));
        end
        chk({tag, "_err"}, 32'(err), 32'(e_err));
        chk({tag, "_pkt_cnt"}, 32'(pkt_cnt), 32'(m_pkt));
        chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(m_err));
    endtask

    task automatic model_reset();
        hq.delete();
        m_in = 0; m_first = 0; m_chan = '0; m_pkt = 0; m_err = 0;
    endtask

    task automatic model_beat(input logic [15:0] d, input bit sop, input bit eop,
                              input bit mty, input logic [1:0] ch);
        bit take;
        int n;
        take = 1;
        e_vld = 0; e_sop = 0; e_eop = 0; e_err = 0; e_dout = '0; e_mty = '0; e_chan = '0;
        if (sop) begin
            if (m_in) e_err = 1;
            hq.delete();
            m_in = 1; m_first = 1; m_chan = ch;
        end else if (!m_in) begin
            e_err = 1; take = 0;
        end else if (ch != m_chan) begin
            e_err = 1;
        end
        if (mty && !eop) e_err = 1;
        if (take) begin
            hq.push_back(d);
            n = hq.size();
            if (eop || n == 2) begin
                e_vld = 1; e_sop = m_first; e_chan = m_chan;
                e_dout = {hq[0], (n == 2) ? hq[1] : 16'h0};
                m_first = 0;
                if (eop) begin
                    // bytes missing from the word: whole absent half-words plus din_mty
                    e_eop = 1;
                    e_mty = 2'(2 * (2 - n) + (mty ? 1 : 0));
                    m_in = 0;
                    m_pkt = (m_pkt + 1) % (1 << CNT_W);
                end
                hq.delete();
            end
        end
        if (e_err && m_err < ERR_MAX) m_err++;
    endtask

    task automatic beat(input string tag, input logic [15:0] d, input bit sop, input bit eop,
                        input bit mty, input logic [1:0] ch);
        @(negedge clk_d);
        din = d; din_vld = 1'b1; din_sop = sop; din_eop = eop; din_mty = mty; din_chan = ch;
        model_beat(d, sop, eop, mty, ch);
        @(posedge clk_d);
        #1;
        din_vld = 1'b0;
        check_outs(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_d);
            din_vld = 1'b0; din_sop = $urandom; din_eop = $urandom; din = 16'($urandom);
            e_vld = 0; e_err = 0;
            @(posedge clk_d);
            #1;
            check_outs(tag);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dout"}, dout, 32'h0);
        chk({tag, "_vld"}, 32'(dout_vld), 32'h0);
        chk({tag, "_sop"}, 32'(dout_sop), 32'h0);
        chk({tag, "_eop"}, 32'(dout_eop), 32'h0);
        chk({tag, "_mty"}, 32'(dout_mty), 32'h0);
        chk({tag, "_chan"}, 32'(dout_chan), 32'h0);
        chk({tag, "_err"}, 32'(err), 32'h0);
        chk({tag, "_pkt_cnt"}, 32'(pkt_cnt), 32'h0);
        chk({tag, "_err_cnt"}, 32'(err_cnt), 32'h0);
    endtask

    task automatic pkt1(input string tag);
        beat({tag, "_b1"}, 16'h1111, 1, 0, 0, 2'd2);
        beat({tag, "_b2"}, 16'h2222, 0, 0, 0, 2'd2);
        chk({tag, "_w1"}, dout, 32'h11112222);
        chk({tag, "_w1sop"}, 32'(dout_sop), 32'h1);
        beat({tag, "_b3"}, 16'h3333, 0, 0, 0, 2'd2);
        beat({tag, "_b4"}, 16'h4444, 0, 1, 0, 2'd2);
        chk({tag, "_w2"}, dout, 32'h33334444);
        chk({tag, "_w2eop"}, 32'(dout_eop), 32'h1);
        chk({tag, "_w2chan"}, 32'(dout_chan), 32'h2);
    endtask

    initial begin
        bit sop, eop, mty;
        logic [1:0] ch;
        rst = 1'b1;
        din = '0; din_vld = 0; din_sop = 0; din_eop = 0; din_mty = 0; din_chan = '0;
        model_reset();
        repeat (2) @(posedge clk_d);
        #1;
        chk_all_zero("reset");
        @(negedge clk_d);
        rst = 1'b0;

        // 1: four-beat packet on channel 2
        pkt1("t1");
        chk("t1_pkt_cnt_1", 32'(pkt_cnt), 32'h1);

        // 2: odd beat count, eop with mty
        beat("t2_b1", 16'hAAAA, 1, 0, 0, 2'd1);
        beat("t2_b2", 16'hBBBB, 0, 0, 0, 2'd1);
        chk("t2_w1", dout, 32'hAAAABBBB);
        beat("t2_b3", 16'hCCCC, 0, 1, 1, 2'd1);
        chk("t2_w2", dout, 32'hCCCC0000);
        chk("t2_mty3", 32'(dout_mty), 32'h3);

        // 3: single-beat packets
        beat("t3_a", 16'h1234, 1, 1, 0, 2'd0);
        chk("t3_a_word", dout, 32'h12340000);
        chk("t3_a_mty2", 32'(dout_mty), 32'h2);
        beat("t3_b", 16'h00AB, 1, 1, 1, 2'd0);
        chk("t3_b_mty3", 32'(dout_mty), 32'h3);

        // 4: test 1 with gaps between beats
        beat("t4_b1", 16'h1111, 1, 0, 0, 2'd2); idle("t4_g1", 3);
        beat("t4_b2", 16'h2222, 0, 0, 0, 2'd2); idle("t4_g2", 3);
        beat("t4_b3", 16'h3333, 0, 0, 0, 2'd2); idle("t4_g3", 3);
        beat("t4_b4", 16'h4444, 0, 1, 0, 2'd2); idle("t4_g4", 3);

        // 5: framing errors
        beat("t5_nosop", 16'h1357, 0, 0, 0, 2'd0);
        chk("t5_err_cnt_1", 32'(err_cnt), 32'h1);
        beat("t5_b1", 16'h5555, 1, 0, 0, 2'd0);
        beat("t5_b2", 16'h6666, 1, 0, 0, 2'd0);
        chk("t5_err_cnt_2", 32'(err_cnt), 32'h2);
        beat("t5_b3", 16'h7777, 0, 1, 0, 2'd0);
        chk("t5_word", dout, 32'h66667777);

        // 6: reset mid-packet
        beat("t6_b1", 16'h1111, 1, 0, 0, 2'd2);
        beat("t6_b2", 16'h2222, 0, 0, 0, 2'd2);
        beat("t6_b3", 16'h3333, 0, 0, 0, 2'd2);
        @(negedge clk_d);
        rst = 1'b1;
        #1;
        chk_all_zero("t6_rst");
        model_reset();
        @(negedge clk_d);
        rst = 1'b0;
        beat("t6_c1", 16'h4444, 0, 1, 0, 2'd2);
        pkt1("t6_clean");
        chk("t6_pkt_cnt_1", 32'(pkt_cnt), 32'h1);

        // random framing: mostly legal, with occasional stray sop/missing sop/bad mty/chan
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(3) == 0) begin
                idle("rnd_gap", 1);
            end else begin
                sop = m_in ? ($urandom_range(15) == 0) : ($urandom_range(7) != 0);
                eop = ($urandom_range(2) == 0);
                mty = eop ? 1'($urandom) : ($urandom_range(19) == 0);
                ch  = (m_in && !sop && $urandom_range(15) != 0) ? m_chan : 2'($urandom_range(2));
                beat("rnd", 16'($urandom), sop, eop, mty, ch);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
